// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master) and a completer (slave).
interface apb_slave_regfile_if;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer holding a bank of 32-bit registers. Register 0 is a read-only ID,
// the rest are read/write. Wait states are inserted through Pready and bad accesses
// are flagged through Pslverr.
module apb_slave_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input logic                Hclk,
  input logic                Hresetn,
  apb_slave_regfile_if.slave apb
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic            err_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     prdata_q;
  logic [31:0]     regs_q [DEPTH];

  logic [31:0]     offset;
  logic [31:0]     word;
  logic [IdxW-1:0] dec_idx;
  logic            dec_err;
  logic [31:0]     dec_rdata;
  logic            setup;
  logic            commit;

  // Address decode of the bus as presented during the setup phase.
  always_comb begin
    offset  = apb.Paddr - BASE_ADDR;
    word    = offset >> 2;
    dec_idx = word[IdxW-1:0];
    dec_err = (apb.Paddr < BASE_ADDR) || (word >= DEPTH) || (apb.Paddr[1:0] != 2'b00) ||
              (apb.Pwrite && (word == 32'd0));
    if (dec_err) begin
      dec_rdata = '0;
    end else if (dec_idx == '0) begin
      dec_rdata = ID_VALUE;
    end else begin
      dec_rdata = regs_q[dec_idx];
    end
  end

  // Transfer sequencing: setup capture, wait-state countdown, completion or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    setup   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        // Penable without a preceding setup is a protocol violation and is ignored.
        if (apb.Psel && !apb.Penable) begin
          setup   = 1'b1;
          state_d = StAccess;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      StAccess: begin
        if (!apb.Psel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (apb.Penable) begin
          commit  = write_q && !err_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state and setup-phase captures.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        write_q <= apb.Pwrite;
        err_q   <= dec_err;
        idx_q   <= dec_idx;
        wdata_q <= apb.Pwdata;
        // Prdata only changes on a read capture; writes leave it alone.
        if (!apb.Pwrite) begin
          prdata_q <= dec_rdata;
        end
      end
    end
  end

  // Register bank; only a clean write completion updates it.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

  // Response outputs; Pready is combinational from state and counter.
  always_comb begin
    apb.Pready  = (state_q == StAccess) && (cnt_q == '0);
    apb.Pslverr = apb.Pready && err_q;
    apb.Prdata  = prdata_q;
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances with 0, 2 and 3 wait states driven by
// per-scenario tasks and checked against a behavioural register-bank model.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'hA5B0_0001;
  localparam int          NREG = 16;

  logic Hclk;
  logic Hresetn;

  logic [2:0]       psel, penable, pwrite;
  logic [2:0][31:0] paddr, pwdata;
  wire  [2:0]       pready, pslverr;
  wire  [2:0][31:0] prdata;

  int vectors;
  int miscompares;
  int cyc;

  // Reference state: register contents and last read data per instance.
  logic [31:0] mem     [3][NREG];
  logic [31:0] last_rd [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_regfile_if bus ();
    assign bus.Psel    = psel[g];
    assign bus.Penable = penable[g];
    assign bus.Pwrite  = pwrite[g];
    assign bus.Paddr   = paddr[g];
    assign bus.Pwdata  = pwdata[g];
    assign pready[g]   = bus.Pready;
    assign pslverr[g]  = bus.Pslverr;
    assign prdata[g]   = bus.Prdata;

    apb_slave_regfile #(
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .Hclk   (Hclk),
      .Hresetn(Hresetn),
      .apb    (bus.slave)
    );
  end

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  always @(posedge Hclk) cyc <= cyc + 1;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic bit m_err(input bit wr, input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return 1'b1;
    off = (a - BASE) / 4;
    if (off >= NREG) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    if (wr && off == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [31:0] a);
    logic [31:0] off;
    if (m_err(1'b0, a)) return 32'h0;
    off = (a - BASE) / 4;
    if (off == 0) return ID;
    return mem[k][off];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      last_rd[k] = 32'h0;
      for (int i = 0; i < NREG; i++) mem[k][i] = 32'h0;
    end
  endtask

  // One APB transfer on instance k; leaves Psel high so a following call is back-to-back.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits);
    @(negedge Hclk);
    psel[k]    = 1'b1;
    penable[k] = 1'b0;
    pwrite[k]  = wr;
    paddr[k]   = a;
    pwdata[k]  = wd;
    @(negedge Hclk);
    penable[k] = 1'b1;
    waits = 0;
    while (pready[k] !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge Hclk);
    end
    if (waits >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout dut%0d addr=%h: Pready never rose", k, a);
    end
    rd  = prdata[k];
    err = pslverr[k];
  endtask

  task automatic bus_idle(input int k);
    @(negedge Hclk);
    psel[k]    = 1'b0;
    penable[k] = 1'b0;
  endtask

  // Full transfer with model update and checks of response, timing and data.
  task automatic checked_xfer(input string name, input int k, input bit wr,
                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, exp_rd;
    logic        err;
    bit          exp_err;
    int          waits;
    exp_err = m_err(wr, a);
    exp_rd  = wr ? last_rd[k] : m_read(k, a);
    xfer(k, wr, a, wd, rd, err, waits);
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL %s slverr dut%0d addr=%h: got %b want %b", name, k, a, err, exp_err);
    end
    vectors++;
    if (waits != ws_of(k)) begin
      miscompares++;
      $display("FAIL %s waits dut%0d addr=%h: got %0d want %0d", name, k, a, waits, ws_of(k));
    end
    vectors++;
    if (rd !== exp_rd) begin
      miscompares++;
      $display("FAIL %s prdata dut%0d addr=%h: got %h want %h", name, k, a, rd, exp_rd);
    end
    if (!wr) last_rd[k] = exp_rd;
    else if (!exp_err) mem[k][(a - BASE) / 4] = wd;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge Hclk);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 32'h0) begin
          miscompares++;
          $display("FAIL reset dut%0d: rdy=%b err=%b rd=%h want 0/0/0",
                   k, pready[k], pslverr[k], prdata[k]);
        end
      end
    end
    // Penable asserted while idle must not start a transfer.
    psel[0]    = 1'b1;
    penable[0] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge Hclk);
      vectors++;
      if (pready[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_penable: Pready got %b want 0", pready[0]);
      end
    end
    psel[0]    = 1'b0;
    penable[0] = 1'b0;
  endtask

  task automatic test_id_read();
    checked_xfer("id_read", 0, 1'b0, BASE, 32'h0);
    bus_idle(0);
  endtask

  task automatic test_wait_states();
    checked_xfer("ws_write", 1, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF);
    bus_idle(1);
    checked_xfer("ws_read", 1, 1'b0, BASE + 32'h4, 32'h0);
    bus_idle(1);
    vectors++;
    if (last_rd[1] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL ws_model readback: got %h want deadbeef", last_rd[1]);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    @(negedge Hclk);
    t0 = cyc;
    checked_xfer("b2b_w8", 0, 1'b1, BASE + 32'h8, 32'hFACE_FEED);
    checked_xfer("b2b_wc", 0, 1'b1, BASE + 32'hC, 32'h1234_5678);
    checked_xfer("b2b_r8", 0, 1'b0, BASE + 32'h8, 32'h0);
    checked_xfer("b2b_rc", 0, 1'b0, BASE + 32'hC, 32'h0);
    bus_idle(0);
    // One lead-in cycle plus two cycles per transfer.
    vectors++;
    if (cyc - t0 != 9) begin
      miscompares++;
      $display("FAIL b2b cycles: got %0d want 9", cyc - t0);
    end
  endtask

  task automatic test_errors();
    checked_xfer("err_w_id", 0, 1'b1, BASE, 32'h1111_1111);
    bus_idle(0);
    checked_xfer("err_w_oor", 0, 1'b1, BASE + 32'h40, 32'h2222_2222);
    bus_idle(0);
    checked_xfer("err_w_mis", 0, 1'b1, BASE + 32'h6, 32'h3333_3333);
    bus_idle(0);
    checked_xfer("err_w_low", 0, 1'b1, 32'h7FFF_FFFC, 32'h4444_4444);
    bus_idle(0);
    for (int i = 0; i < 4; i++) begin
      checked_xfer("err_readback", 0, 1'b0, BASE + 32'(4 * i), 32'h0);
      bus_idle(0);
    end
    checked_xfer("err_r_oor", 0, 1'b0, BASE + 32'h40, 32'h0);
    bus_idle(0);
  endtask

  task automatic test_abort();
    @(negedge Hclk);
    psel[2]    = 1'b1;
    penable[2] = 1'b0;
    pwrite[2]  = 1'b1;
    paddr[2]   = BASE + 32'h10;
    pwdata[2]  = 32'hCAFE_0000;
    @(negedge Hclk);
    penable[2] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      vectors++;
      if (pready[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL abort access%0d: Pready got %b want 0", n, pready[2]);
      end
      if (n == 0) @(negedge Hclk);
    end
    psel[2]    = 1'b0;
    penable[2] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge Hclk);
      vectors++;
      if (pready[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL abort after%0d: Pready got %b want 0", n, pready[2]);
      end
    end
    checked_xfer("abort_read4", 2, 1'b0, BASE + 32'h10, 32'h0);
    bus_idle(2);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          k;
    bit          wr;
    for (int n = 0; n < 60; n++) begin
      k  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = 32'h7FFF_FFFC - 32'(4 * $urandom_range(0, 8));
        1:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        2:       a = BASE + 32'h40 + 32'(4 * $urandom_range(0, 100));
        default: a = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      checked_xfer("random", k, wr, a, $urandom);
      bus_idle(k);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        err;
    int          waits;
    checked_xfer("rst_prep_w5", 1, 1'b1, BASE + 32'h14, 32'h5555_AAAA);
    bus_idle(1);
    checked_xfer("rst_prep_r1", 1, 1'b0, BASE + 32'h4, 32'h0);
    bus_idle(1);
    @(negedge Hclk);
    psel[1]    = 1'b1;
    penable[1] = 1'b0;
    pwrite[1]  = 1'b1;
    paddr[1]   = BASE + 32'h14;
    pwdata[1]  = 32'h0BAD_F00D;
    @(negedge Hclk);
    penable[1] = 1'b1;
    @(negedge Hclk);
    #2 Hresetn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (pready[k] !== 1'b0 || prdata[k] !== 32'h0 || pslverr[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid dut%0d: rdy=%b rd=%h err=%b want 0/0/0",
                 k, pready[k], prdata[k], pslverr[k]);
      end
    end
    psel[1]    = 1'b0;
    penable[1] = 1'b0;
    model_reset();
    @(negedge Hclk);
    Hresetn = 1'b1;
    checked_xfer("rst_read5", 1, 1'b0, BASE + 32'h14, 32'h0);
    bus_idle(1);
    xfer(1, 1'b0, BASE + 32'h4, 32'h0, rd, err, waits);
    bus_idle(1);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_read1: got %h want 0", rd);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    Hresetn     = 1'b0;
    psel        = '0;
    penable     = '0;
    pwrite      = '0;
    paddr       = '0;
    pwdata      = '0;
    model_reset();
    repeat (3) @(negedge Hclk);
    Hresetn = 1'b1;
    test_reset();
    test_id_read();
    test_wait_states();
    test_back_to_back();
    test_errors();
    test_abort();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge Hclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
